// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared constants and types for the pipeline-register / stall-response block.
package pipe_stall_ctrl_pkg;

    localparam logic [31:0] PC_RESET_DEFAULT  = 32'h0000_3000;
    localparam logic [31:0] NOP_INSTR         = 32'h0000_0000;

    // Payload widths shared with the datapath
    localparam int unsigned DE_W_DEFAULT      = 96;
    localparam int unsigned EM_W_DEFAULT      = 64;
    localparam int unsigned MW_W_DEFAULT      = 64;
    localparam int unsigned MAX_STALL_DEFAULT = 2;

    // Stall watchdog states
    typedef enum logic [1:0] {
        StRun  = 2'b00,
        StHold = 2'b01,
        StErr  = 2'b10
    } wd_state_e;

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Datapath-facing bundle of the stall controller.
// stall_cycles exists only when PIPE_STALL_CNT_EN is defined.
interface pipe_stall_ctrl_if
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int unsigned DE_W = DE_W_DEFAULT,
    parameter int unsigned EM_W = EM_W_DEFAULT,
    parameter int unsigned MW_W = MW_W_DEFAULT
);
    logic            stall;
    logic [31:0]     npc;
    logic [31:0]     F_instr;
    logic [DE_W-1:0] D_payload;
    logic [EM_W-1:0] E_payload;
    logic [MW_W-1:0] M_payload;

    logic [31:0]     F_pc;
    logic [31:0]     D_instr, D_pc;
    logic            D_valid;
    logic [31:0]     E_instr, E_pc;
    logic            E_valid;
    logic [DE_W-1:0] E_payload_q;
    logic [31:0]     M_instr, M_pc;
    logic            M_valid;
    logic [EM_W-1:0] M_payload_q;
    logic [31:0]     W_instr, W_pc;
    logic            W_valid;
    logic [MW_W-1:0] W_payload_q;
    logic            stall_err;
`ifdef PIPE_STALL_CNT_EN
    logic [31:0]     stall_cycles;
`endif

    // Hazard unit / datapath side
    modport master (
        output stall, npc, F_instr, D_payload, E_payload, M_payload,
`ifdef PIPE_STALL_CNT_EN
        input  stall_cycles,
`endif
        input  F_pc, D_instr, D_pc, D_valid, E_instr, E_pc, E_valid, E_payload_q,
        input  M_instr, M_pc, M_valid, M_payload_q, W_instr, W_pc, W_valid, W_payload_q,
        input  stall_err
    );

    // Stall controller side
    modport slave (
        input  stall, npc, F_instr, D_payload, E_payload, M_payload,
`ifdef PIPE_STALL_CNT_EN
        output stall_cycles,
`endif
        output F_pc, D_instr, D_pc, D_valid, E_instr, E_pc, E_valid, E_payload_q,
        output M_instr, M_pc, M_valid, M_payload_q, W_instr, W_pc, W_valid, W_payload_q,
        output stall_err
    );

endinterface

// File: rtl/pipe_stall_ctrl_pipe_reg.sv
// One pipeline stage register of {instr, pc, valid, payload}.
// clr loads a bubble and takes priority over en.
module pipe_reg
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int unsigned PW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          clr,
    input  logic [31:0]   instr,
    input  logic [31:0]   pc,
    input  logic          valid,
    input  logic [PW-1:0] payload,
    output logic [31:0]   instr_q,
    output logic [31:0]   pc_q,
    output logic          valid_q,
    output logic [PW-1:0] payload_q
);

    // Reset and clr both produce a bubble; otherwise load when enabled
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            instr_q   <= NOP_INSTR;
            pc_q      <= '0;
            valid_q   <= 1'b0;
            payload_q <= '0;
        end else if (en) begin
            instr_q   <= instr;
            pc_q      <= pc;
            valid_q   <= valid;
            payload_q <= payload;
        end
    end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// PC and F/D, D/E, E/M, M/W stage registers with stall response and a
// stall run-length watchdog. Optional stall cycle counter: PIPE_STALL_CNT_EN.
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter logic [31:0] PC_RESET  = PC_RESET_DEFAULT,
    parameter int unsigned DE_W      = DE_W_DEFAULT,
    parameter int unsigned EM_W      = EM_W_DEFAULT,
    parameter int unsigned MW_W      = MW_W_DEFAULT,
    parameter int unsigned MAX_STALL = MAX_STALL_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    pipe_stall_ctrl_if.slave bus
);

    localparam int unsigned   RunW     = $clog2(MAX_STALL + 2);
    localparam logic [RunW-1:0] RunOne   = RunW'(1);
    localparam logic [RunW-1:0] RunLimit = RunW'(MAX_STALL);
    localparam logic [RunW-1:0] RunMax   = RunW'(MAX_STALL + 1);

    logic [31:0]     pc_q;
    logic [31:0]     d_instr, d_pc, e_instr, e_pc, m_instr, m_pc;
    logic            d_valid, e_valid, m_valid;
    logic [DE_W-1:0] e_payload;
    logic [EM_W-1:0] m_payload;
    logic            fd_payload_unused;

    // Fetch PC holds while stalled
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= PC_RESET;
        end else if (!bus.stall) begin
            pc_q <= bus.npc;
        end
    end

    pipe_reg #(.PW(1)) u_fd (
        .clk(clk), .reset(reset), .en(!bus.stall), .clr(1'b0),
        .instr(bus.F_instr), .pc(pc_q), .valid(1'b1), .payload(1'b0),
        .instr_q(d_instr), .pc_q(d_pc), .valid_q(d_valid), .payload_q(fd_payload_unused)
    );

    pipe_reg #(.PW(DE_W)) u_de (
        .clk(clk), .reset(reset), .en(1'b1), .clr(bus.stall),
        .instr(d_instr), .pc(d_pc), .valid(d_valid), .payload(bus.D_payload),
        .instr_q(e_instr), .pc_q(e_pc), .valid_q(e_valid), .payload_q(e_payload)
    );

    pipe_reg #(.PW(EM_W)) u_em (
        .clk(clk), .reset(reset), .en(1'b1), .clr(1'b0),
        .instr(e_instr), .pc(e_pc), .valid(e_valid), .payload(bus.E_payload),
        .instr_q(m_instr), .pc_q(m_pc), .valid_q(m_valid), .payload_q(m_payload)
    );

    pipe_reg #(.PW(MW_W)) u_mw (
        .clk(clk), .reset(reset), .en(1'b1), .clr(1'b0),
        .instr(m_instr), .pc(m_pc), .valid(m_valid), .payload(bus.M_payload),
        .instr_q(bus.W_instr), .pc_q(bus.W_pc), .valid_q(bus.W_valid),
        .payload_q(bus.W_payload_q)
    );

    assign bus.F_pc        = pc_q;
    assign bus.D_instr     = d_instr;
    assign bus.D_pc        = d_pc;
    assign bus.D_valid     = d_valid;
    assign bus.E_instr     = e_instr;
    assign bus.E_pc        = e_pc;
    assign bus.E_valid     = e_valid;
    assign bus.E_payload_q = e_payload;
    assign bus.M_instr     = m_instr;
    assign bus.M_pc        = m_pc;
    assign bus.M_valid     = m_valid;
    assign bus.M_payload_q = m_payload;

    wd_state_e       state_q, state_d;
    logic [RunW-1:0] run_q, run_d;
    logic            stall_err_q, stall_err_d;

    // Watchdog state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StRun;
            run_q       <= '0;
            stall_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            run_q       <= run_d;
            stall_err_q <= stall_err_d;
        end
    end

    // Watchdog next state: count consecutive stalls, trap once over the limit
    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        unique case (state_q)
            StRun: begin
                if (bus.stall) begin
                    run_d   = RunOne;
                    state_d = (RunOne > RunLimit) ? StErr : StHold;
                end
            end
            StHold: begin
                if (bus.stall) begin
                    run_d = (run_q == RunMax) ? run_q : run_q + RunOne;
                    if (run_d > RunLimit) begin
                        state_d = StErr;
                    end
                end else begin
                    state_d = StRun;
                    run_d   = '0;
                end
            end
            StErr: begin
                state_d = StErr;
            end
            default: begin
                state_d = StRun;
                run_d   = '0;
            end
        endcase
    end

    // Watchdog output: error flag tracks entry into the absorbing ERR state
    always_comb begin
        stall_err_d = (state_d == StErr);
    end

    assign bus.stall_err = stall_err_q;

`ifdef PIPE_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    // Saturating count of stalled clock edges
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else if (bus.stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign bus.stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl; checks pipeline PCs/valids/instrs,
// bubbles, payload transport, watchdog and (when built) the stall counter.
module tb_pipe_stall_ctrl;
    import pipe_stall_ctrl_pkg::*;

    localparam logic [95:0] DP = 96'hD1D1_0000_D2D2_0000_D3D3_0001;
    localparam logic [63:0] EP = 64'hE1E1_2222_E3E3_4444;
    localparam logic [63:0] MP = 64'h5A5A_0F0F_A5A5_F0F0;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [31:0] fpc_m;

    always #5 clk = ~clk;

    pipe_stall_ctrl_if bus ();

    pipe_stall_ctrl dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return pc ^ 32'hA5A5_0000;
    endfunction

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Valid and instr follow from the expected pc: pc 0 is a bubble
    task automatic chk_stage(input string tag, input logic [31:0] pc_o,
                             input logic [31:0] instr_o, input logic valid_o,
                             input logic [31:0] pc_e);
        chk({tag, "_pc"}, 96'(pc_o), 96'(pc_e));
        chk({tag, "_valid"}, 96'(valid_o), 96'(pc_e != 32'h0));
        chk({tag, "_instr"}, 96'(instr_o), 96'((pc_e == 32'h0) ? NOP_INSTR : instr_of(pc_e)));
    endtask

    task automatic chk_pipe(input string tag, input logic [31:0] f, input logic [31:0] d,
                            input logic [31:0] e, input logic [31:0] m, input logic [31:0] w);
        chk({tag, "_F_pc"}, 96'(bus.F_pc), 96'(f));
        chk_stage({tag, "_D"}, bus.D_pc, bus.D_instr, bus.D_valid, d);
        chk_stage({tag, "_E"}, bus.E_pc, bus.E_instr, bus.E_valid, e);
        chk_stage({tag, "_M"}, bus.M_pc, bus.M_instr, bus.M_valid, m);
        chk_stage({tag, "_W"}, bus.W_pc, bus.W_instr, bus.W_valid, w);
    endtask

    // One clock: fetch supplies instr_of(F_pc) and npc = F_pc + 4
    task automatic cyc(input logic s, input logic r);
        bus.stall   = s;
        reset       = r;
        bus.F_instr = instr_of(fpc_m);
        bus.npc     = fpc_m + 32'd4;
        @(posedge clk);
        #1;
        if (r) fpc_m = PC_RESET_DEFAULT;
        else if (!s) fpc_m = fpc_m + 32'd4;
    endtask

    initial begin
        bus.D_payload = DP;
        bus.E_payload = EP;
        bus.M_payload = MP;
        fpc_m = 32'h0;

        cyc(1'b0, 1'b1);
        chk_pipe("rst", 32'h3000, 0, 0, 0, 0);
        chk("rst_err", 96'(bus.stall_err), 96'(0));
        chk("rst_Epay", 96'(bus.E_payload_q), 96'(0));

        cyc(1'b0, 1'b0);
        chk_pipe("c1", 32'h3004, 32'h3000, 0, 0, 0);
        cyc(1'b0, 1'b0);
        chk_pipe("c2", 32'h3008, 32'h3004, 32'h3000, 0, 0);
        cyc(1'b0, 1'b0);
        chk_pipe("c3", 32'h300C, 32'h3008, 32'h3004, 32'h3000, 0);
        cyc(1'b0, 1'b0);
        chk_pipe("c4", 32'h3010, 32'h300C, 32'h3008, 32'h3004, 32'h3000);
        chk("c4_Epay", 96'(bus.E_payload_q), DP);
        chk("c4_Mpay", 96'(bus.M_payload_q), 96'(EP));
        chk("c4_Wpay", 96'(bus.W_payload_q), 96'(MP));

        // single stall
        cyc(1'b1, 1'b0);
        chk_pipe("s1", 32'h3010, 32'h300C, 0, 32'h3008, 32'h3004);
        chk("s1_Epay", 96'(bus.E_payload_q), 96'(0));
        chk("s1_err", 96'(bus.stall_err), 96'(0));
        cyc(1'b0, 1'b0);
        chk_pipe("c6", 32'h3014, 32'h3010, 32'h300C, 0, 32'h3008);
        cyc(1'b0, 1'b0);
        chk_pipe("c7", 32'h3018, 32'h3014, 32'h3010, 32'h300C, 0);

        // two-cycle load-use stall
        cyc(1'b1, 1'b0);
        chk_pipe("s2a", 32'h3018, 32'h3014, 0, 32'h3010, 32'h300C);
        cyc(1'b1, 1'b0);
        chk_pipe("s2b", 32'h3018, 32'h3014, 0, 0, 32'h3010);
        chk("s2b_err", 96'(bus.stall_err), 96'(0));
        cyc(1'b0, 1'b0);
        chk_pipe("c10", 32'h301C, 32'h3018, 32'h3014, 0, 0);
        cyc(1'b0, 1'b0);
        chk_pipe("c11", 32'h3020, 32'h301C, 32'h3018, 32'h3014, 0);
        chk("c11_err", 96'(bus.stall_err), 96'(0));
        cyc(1'b0, 1'b0);
        chk_pipe("c12", 32'h3024, 32'h3020, 32'h301C, 32'h3018, 32'h3014);

        // three stalls: watchdog trips after the third edge
        cyc(1'b1, 1'b0);
        chk("s3a_err", 96'(bus.stall_err), 96'(0));
        cyc(1'b1, 1'b0);
        chk("s3b_err", 96'(bus.stall_err), 96'(0));
        cyc(1'b1, 1'b0);
        chk_pipe("s3c", 32'h3024, 32'h3020, 0, 0, 0);
        chk("s3c_err", 96'(bus.stall_err), 96'(1));
        cyc(1'b0, 1'b0);
        chk_pipe("c16", 32'h3028, 32'h3024, 32'h3020, 0, 0);
        chk("c16_err", 96'(bus.stall_err), 96'(1));
        cyc(1'b1, 1'b0);
        chk_pipe("c17", 32'h3028, 32'h3024, 0, 32'h3020, 0);
        chk("c17_err", 96'(bus.stall_err), 96'(1));

        // reset together with stall, pipeline non-empty
        cyc(1'b1, 1'b1);
        chk_pipe("rs", 32'h3000, 0, 0, 0, 0);
        chk("rs_err", 96'(bus.stall_err), 96'(0));
        chk("rs_Epay", 96'(bus.E_payload_q), 96'(0));
        chk("rs_Mpay", 96'(bus.M_payload_q), 96'(0));
        chk("rs_Wpay", 96'(bus.W_payload_q), 96'(0));

        // stall in the first cycle after reset
        cyc(1'b1, 1'b0);
        chk_pipe("fs", 32'h3000, 0, 0, 0, 0);
        cyc(1'b0, 1'b0);
        chk_pipe("fs2", 32'h3004, 32'h3000, 0, 0, 0);
        chk("fs2_err", 96'(bus.stall_err), 96'(0));

`ifdef PIPE_STALL_CNT_EN
        // one stall so far since reset, four more scattered
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        chk("cnt5", 96'(bus.stall_cycles), 96'(5));
        force dut.stall_cnt_q = 32'hFFFF_FFFE;
        cyc(1'b0, 1'b0);
        release dut.stall_cnt_q;
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        chk("cnt_sat", 96'(bus.stall_cycles), 96'(32'hFFFF_FFFF));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
